// File: rtl/matvec_sched_pkg.sv
// Shared types and sizing helpers for the matvec engine scheduler slice.
package matvec_sched_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_ROWS   = 64;
    localparam int DEF_MAX_COLS   = 64;
    localparam int DEF_BANDWIDTH  = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_W     = 14;

    // Counts need one extra bit so that the full MAX value itself is representable.
    function automatic int cnt_w(input int max_v);
        return $clog2(max_v) + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = cnt_w(DEF_MAX_ROWS);
    localparam int COL_W = cnt_w(DEF_MAX_COLS);
    localparam int TAG_W = idx_w(DEF_NUM_REQ);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_GRANT = 6'b000010,
        S_START = 6'b000100,
        S_VLOAD = 6'b001000,
        S_RUN   = 6'b010000,
        S_DRAIN = 6'b100000
    } state_t;

endpackage

// File: rtl/matvec_scheduler_if.sv
// Engine and weight-SRAM side of the scheduler: master = scheduler, slave = engine/SRAM.
interface matvec_scheduler_if
    import matvec_sched_pkg::*;
#(
    parameter int MAX_ROWS   = DEF_MAX_ROWS,
    parameter int MAX_COLS   = DEF_MAX_COLS,
    parameter int BANDWIDTH  = DEF_BANDWIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
) ();
    localparam int RW      = cnt_w(MAX_ROWS);
    localparam int CW      = cnt_w(MAX_COLS);
    localparam int VADDR_W = $clog2(MAX_COLS);
    localparam int MADDR_W = $clog2(MAX_ROWS * MAX_COLS);

    logic                            eng_start;
    logic [RW-1:0]                   eng_num_rows;
    logic [CW-1:0]                   eng_num_cols;
    logic                            eng_vec_we;
    logic [VADDR_W-1:0]              eng_vec_addr;
    logic [DATA_WIDTH*BANDWIDTH-1:0] eng_vec_data;
    logic [MADDR_W-1:0]              eng_matrix_addr;
    logic                            eng_matrix_enable;
    logic [2*DATA_WIDTH-1:0]         eng_result;
    logic                            eng_result_valid;
    logic                            eng_busy;
    logic [ADDR_W-1:0]               mem_addr;
    logic                            mem_enable;

    modport master (
        output eng_start, eng_num_rows, eng_num_cols, eng_vec_we, eng_vec_addr, eng_vec_data,
        output mem_addr, mem_enable,
        input  eng_matrix_addr, eng_matrix_enable, eng_result, eng_result_valid, eng_busy
    );

    modport slave (
        input  eng_start, eng_num_rows, eng_num_cols, eng_vec_we, eng_vec_addr, eng_vec_data,
        input  mem_addr, mem_enable,
        output eng_matrix_addr, eng_matrix_enable, eng_result, eng_result_valid, eng_busy
    );

endinterface

// File: rtl/matvec_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping around.
module rr_arbiter
    import matvec_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_s;

    // Scan from ptr upward; the first hit wins and masks the rest.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                idx           = cand_s;
                grant[cand_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/matvec_scheduler.sv
// Shares one matvec engine among NUM_REQ requesters: grant, descriptor check, vector load, result tagging.
module matvec_scheduler
    import matvec_sched_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int MAX_ROWS   = DEF_MAX_ROWS,
    parameter  int MAX_COLS   = DEF_MAX_COLS,
    parameter  int BANDWIDTH  = DEF_BANDWIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ADDR_W     = DEF_ADDR_W,
    localparam int RW         = cnt_w(MAX_ROWS),
    localparam int CW         = cnt_w(MAX_COLS),
    localparam int TW         = idx_w(NUM_REQ),
    localparam int RIDX_W     = $clog2(MAX_ROWS),
    localparam int VADDR_W    = $clog2(MAX_COLS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*RW-1:0]           job_rows,
    input  logic [NUM_REQ*CW-1:0]           job_cols,
    input  logic [NUM_REQ*ADDR_W-1:0]       job_base,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    input  logic                            vec_valid,
    input  logic [DATA_WIDTH*BANDWIDTH-1:0] vec_data,
    output logic                            vec_ready,
    matvec_scheduler_if.master              eng,
    output logic                            res_valid,
    output logic [2*DATA_WIDTH-1:0]         res_data,
    output logic [TW-1:0]                   res_tag,
    output logic [RIDX_W-1:0]               res_row,
    output logic                            busy
);

    state_t                  state_r;
    logic [TW-1:0]           rr_ptr_r;
    logic [TW-1:0]           owner_r;
    logic [NUM_REQ-1:0]      owner_oh_r;
    logic [NUM_REQ-1:0]      done_r;
    logic [NUM_REQ-1:0]      err_r;
    logic [RW-1:0]           rows_r;
    logic [CW-1:0]           cols_r;
    logic [ADDR_W-1:0]       base_r;
    logic [VADDR_W-1:0]      vec_addr_r;
    logic [RIDX_W-1:0]       row_cnt_r;
    logic [RW-1:0]           num_rows_r;
    logic [CW-1:0]           num_cols_r;
    logic                    res_valid_r;
    logic [2*DATA_WIDTH-1:0] res_data_r;
    logic [TW-1:0]           res_tag_r;
    logic [RIDX_W-1:0]       res_row_r;

    logic [NUM_REQ-1:0]      arb_grant_s;
    logic [TW-1:0]           arb_idx_s;
    logic                    arb_any_s;
    logic                    desc_bad_s;
    logic                    last_chunk_s;
    logic                    last_row_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    assign desc_bad_s   = (rows_r == '0) || (cols_r == '0) ||
                          (rows_r > RW'(MAX_ROWS)) || (cols_r > CW'(MAX_COLS));
    // Current chunk is the last one once it covers the remaining columns.
    assign last_chunk_s = (CW'(vec_addr_r) + CW'(BANDWIDTH)) >= cols_r;
    assign last_row_s   = (RW'(row_cnt_r) + RW'(1)) == rows_r;

    assign gnt           = (state_r == S_GRANT) ? owner_oh_r : '0;
    assign done          = done_r;
    assign err           = err_r;
    assign vec_ready     = (state_r == S_VLOAD);
    assign busy          = (state_r != S_IDLE);
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign res_tag       = res_tag_r;
    assign res_row       = res_row_r;

    assign eng.eng_start    = (state_r == S_START);
    assign eng.eng_num_rows = num_rows_r;
    assign eng.eng_num_cols = num_cols_r;
    assign eng.eng_vec_we   = vec_ready && vec_valid;
    assign eng.eng_vec_addr = vec_addr_r;
    assign eng.eng_vec_data = vec_data;
    assign eng.mem_addr     = base_r + ADDR_W'(eng.eng_matrix_addr);
    assign eng.mem_enable   = eng.eng_matrix_enable;

    // Job sequencing FSM together with its counters and the registered result port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            rr_ptr_r    <= '0;
            owner_r     <= '0;
            owner_oh_r  <= '0;
            done_r      <= '0;
            err_r       <= '0;
            rows_r      <= '0;
            cols_r      <= '0;
            base_r      <= '0;
            vec_addr_r  <= '0;
            row_cnt_r   <= '0;
            num_rows_r  <= '0;
            num_cols_r  <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_tag_r   <= '0;
            res_row_r   <= '0;
        end else begin
            done_r      <= '0;
            err_r       <= '0;
            res_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (arb_any_s) begin
                        owner_r    <= arb_idx_s;
                        owner_oh_r <= arb_grant_s;
                        rows_r     <= job_rows[int'(arb_idx_s)*RW +: RW];
                        cols_r     <= job_cols[int'(arb_idx_s)*CW +: CW];
                        base_r     <= job_base[int'(arb_idx_s)*ADDR_W +: ADDR_W];
                        state_r    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    rr_ptr_r <= (owner_r == TW'(NUM_REQ - 1)) ? '0 : owner_r + TW'(1);
                    if (desc_bad_s) begin
                        err_r   <= owner_oh_r;
                        state_r <= S_IDLE;
                    end else begin
                        num_rows_r <= rows_r;
                        num_cols_r <= cols_r;
                        state_r    <= S_START;
                    end
                end
                S_START: begin
                    vec_addr_r <= '0;
                    row_cnt_r  <= '0;
                    state_r    <= S_VLOAD;
                end
                S_VLOAD: begin
                    if (vec_valid) begin
                        if (last_chunk_s) begin
                            state_r <= S_RUN;
                        end else begin
                            vec_addr_r <= vec_addr_r + VADDR_W'(BANDWIDTH);
                        end
                    end
                end
                S_RUN: begin
                    if (eng.eng_result_valid) begin
                        res_valid_r <= 1'b1;
                        res_data_r  <= eng.eng_result;
                        res_tag_r   <= owner_r;
                        res_row_r   <= row_cnt_r;
                        row_cnt_r   <= row_cnt_r + RIDX_W'(1);
                        if (last_row_s) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!eng.eng_busy) begin
                        done_r  <= owner_oh_r;
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_scheduler.sv
// Directed bench for matvec_scheduler; the bench plays the engine and the requesters.
module tb_matvec_scheduler;
    import matvec_sched_pkg::*;

    localparam int NR = 4;
    localparam int MR = 64;
    localparam int MC = 64;
    localparam int BW = 16;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int RW = 7;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*RW-1:0] job_rows;
    logic [NR*CW-1:0] job_cols;
    logic [NR*AW-1:0] job_base;
    logic [NR-1:0]   gnt, done, err;
    logic            vec_valid;
    logic [DW*BW-1:0] vec_data;
    logic            vec_ready;
    logic            res_valid;
    logic [2*DW-1:0] res_data;
    logic [1:0]      res_tag;
    logic [5:0]      res_row;
    logic            busy;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int start_cnt  = 0;
    int           we_addr_q[$];
    logic [31:0]  we_data_q[$];
    logic [NR-1:0] gnt_q[$];
    logic [39:0]  res_q[$];

    always #5 clk = ~clk;

    matvec_scheduler_if #(.MAX_ROWS(MR), .MAX_COLS(MC), .BANDWIDTH(BW),
                          .DATA_WIDTH(DW), .ADDR_W(AW)) eng_bus ();

    matvec_scheduler #(.NUM_REQ(NR), .MAX_ROWS(MR), .MAX_COLS(MC), .BANDWIDTH(BW),
                       .DATA_WIDTH(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .job_rows  (job_rows),
        .job_cols  (job_cols),
        .job_base  (job_base),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .eng       (eng_bus),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_row   (res_row),
        .busy      (busy)
    );

    // Mid-cycle observer of pulses and strobes.
    always @(negedge clk) begin
        if (eng_bus.eng_start) start_cnt++;
        if (eng_bus.eng_vec_we) begin
            we_addr_q.push_back(int'(eng_bus.eng_vec_addr));
            we_data_q.push_back({eng_bus.eng_vec_data[255:240], eng_bus.eng_vec_data[15:0]});
        end
        if (gnt != '0) gnt_q.push_back(gnt);
        if (res_valid) res_q.push_back({res_tag, res_row, res_data});
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int r, input int rows, input int cols, input int base);
        job_rows[r*RW +: RW] = RW'(rows);
        job_cols[r*CW +: CW] = CW'(cols);
        job_base[r*AW +: AW] = AW'(base);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!vec_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("vload_reached", 64'(vec_ready), 64'd1);
    endtask

    task automatic do_job(input int r, input int rows, input int cols, input int base,
                          input int stall, input bit keep_req, input bit stray);
        int chunks = (cols + BW - 1) / BW;
        int n = 0;
        start_cnt = 0;
        we_addr_q.delete();
        we_data_q.delete();
        res_q.delete();
        wait_ready();
        if (!keep_req) req[r] = 1'b0;
        check_eq("num_rows", 64'(eng_bus.eng_num_rows), 64'(rows));
        check_eq("num_cols", 64'(eng_bus.eng_num_cols), 64'(cols));
        if (stray) begin
            eng_bus.eng_result_valid = 1'b1;
            eng_bus.eng_result = 32'hDEAD_BEEF;
            tick();
            eng_bus.eng_result_valid = 1'b0;
            tick();
            check_eq("stray_res_valid", 64'(res_valid), 64'd0);
        end
        for (int c = 0; c < chunks; c++) begin
            vec_valid = 1'b1;
            vec_data = '0;
            vec_data[15:0] = 16'(100 * r + c);
            vec_data[255:240] = 16'(c + 1);
            tick();
            vec_valid = 1'b0;
            for (int s = 0; s < stall; s++) tick();
        end
        eng_bus.eng_busy = 1'b1;
        for (int row = 0; row < rows; row++) begin
            eng_bus.eng_matrix_addr = 12'(row);
            eng_bus.eng_matrix_enable = 1'b1;
            #1;
            check_eq("mem_addr", 64'(eng_bus.mem_addr), 64'(AW'(base + row)));
            eng_bus.eng_result_valid = 1'b1;
            eng_bus.eng_result = 32'(r * 65536 + row * 3 + 1);
            tick();
            eng_bus.eng_result_valid = 1'b0;
            tick();
        end
        eng_bus.eng_matrix_enable = 1'b0;
        tick();
        check_eq("done_while_busy", 64'(done), 64'd0);
        tick();
        check_eq("done_while_busy", 64'(done), 64'd0);
        eng_bus.eng_busy = 1'b0;
        while (done == '0 && n < 10) begin
            tick();
            n++;
        end
        check_eq("done", 64'(done), 64'(1 << r));
        check_eq("start_count", 64'(start_cnt), 64'd1);
        check_eq("chunk_count", 64'(we_addr_q.size()), 64'(chunks));
        for (int c = 0; c < chunks && c < we_addr_q.size(); c++) begin
            check_eq("chunk_addr", 64'(we_addr_q[c]), 64'(c * BW));
            check_eq("chunk_data", 64'(we_data_q[c]), {32'd0, 16'(c + 1), 16'(100 * r + c)});
        end
        check_eq("result_count", 64'(res_q.size()), 64'(rows));
        for (int row = 0; row < rows && row < res_q.size(); row++) begin
            check_eq("result", 64'(res_q[row]), {24'd0, 2'(r), 6'(row), 32'(r * 65536 + row * 3 + 1)});
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_gnt", 64'(gnt), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_vec_ready", 64'(vec_ready), 64'd0);
        check_eq("rst_eng_start", 64'(eng_bus.eng_start), 64'd0);
        check_eq("rst_eng_vec_we", 64'(eng_bus.eng_vec_we), 64'd0);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_data", 64'(res_data), 64'd0);
        check_eq("rst_res_row", 64'(res_row), 64'd0);
        check_eq("rst_res_tag", 64'(res_tag), 64'd0);
        check_eq("rst_num_rows", 64'(eng_bus.eng_num_rows), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        job_rows = '0;
        job_cols = '0;
        job_base = '0;
        vec_valid = 1'b0;
        vec_data = '0;
        eng_bus.eng_matrix_addr = '0;
        eng_bus.eng_matrix_enable = 1'b0;
        eng_bus.eng_result = '0;
        eng_bus.eng_result_valid = 1'b0;
        eng_bus.eng_busy = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Single job with a stray engine strobe during vector load.
        set_job(0, 4, 16, 'h100);
        req = 4'b0001;
        do_job(0, 4, 16, 'h100, 0, 1'b0, 1'b1);
        eng_bus.eng_matrix_addr = 12'd5;
        eng_bus.eng_matrix_enable = 1'b1;
        #1;
        check_eq("mem_addr_0x105", 64'(eng_bus.mem_addr), 64'h105);
        check_eq("mem_enable", 64'(eng_bus.mem_enable), 64'd1);
        eng_bus.eng_matrix_enable = 1'b0;
        tick();

        // Three chunks with a 5-cycle stall between them.
        set_job(1, 2, 40, 'h200);
        req = 4'b0010;
        do_job(1, 2, 40, 'h200, 5, 1'b0, 1'b0);
        tick();

        // Fairness with all four requests held.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++) set_job(r, 1, 16, 'h40 * r);
        gnt_q.delete();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) do_job(j % NR, 1, 16, 'h40 * (j % NR), 0, 1'b1, 1'b0);
        req = '0;
        tick();
        check_eq("rr_grant_count", 64'(gnt_q.size()), 64'd5);
        for (int j = 0; j < 5 && j < gnt_q.size(); j++)
            check_eq("rr_grant_order", 64'(gnt_q[j]), 64'(1 << (j % NR)));

        // Rejected descriptor on requester 2, then requester 3 is served.
        begin
            int n = 0;
            set_job(2, 0, 16, 'h300);
            set_job(3, 2, 16, 'h380);
            gnt_q.delete();
            start_cnt = 0;
            req = 4'b1100;
            while (gnt == '0 && n < 10) begin
                tick();
                n++;
            end
            check_eq("bad_desc_gnt", 64'(gnt), 64'b0100);
            req[2] = 1'b0;
            tick();
            check_eq("bad_desc_err", 64'(err), 64'b0100);
            check_eq("bad_desc_no_start", 64'(start_cnt), 64'd0);
            tick();
            check_eq("err_pulse_width", 64'(err), 64'd0);
            do_job(3, 2, 16, 'h380, 0, 1'b0, 1'b0);
            check_eq("after_err_grants", 64'(gnt_q.size()), 64'd2);
            if (gnt_q.size() == 2) check_eq("after_err_next", 64'(gnt_q[1]), 64'b1000);
        end
        tick();

        // Reset asserted in the middle of the result phase.
        set_job(0, 4, 16, 'h100);
        req = 4'b0001;
        wait_ready();
        req = '0;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        eng_bus.eng_busy = 1'b1;
        eng_bus.eng_result_valid = 1'b1;
        eng_bus.eng_result = 32'h1234_5678;
        tick();
        eng_bus.eng_result_valid = 1'b0;
        check_eq("pre_reset_res_valid", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        eng_bus.eng_busy = 1'b0;
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        set_job(1, 2, 16, 'h500);
        req = 4'b0010;
        do_job(1, 2, 16, 'h500, 0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/matvec_scheduler.md
Name: matvec_scheduler

Overview:
- Round-robin scheduler that shares one matvec_multiplier engine among NUM_REQ requesters (LSTM gate units: W·x, U·h jobs).
- Latches a job descriptor (rows, cols, matrix base), starts the engine, and streams the requester's vector chunks into it.
- Relocates engine matrix addresses into the shared weight SRAM and returns per-row results tagged with requester ID and row index.
- Sits between the gate controllers and the engine/SRAM loader.

Parameters:
NUM_REQ, 4, number of requesters
MAX_ROWS, 64, engine max rows
MAX_COLS, 64, engine max cols
BANDWIDTH, 16, elements per vector chunk / SRAM word
DATA_WIDTH, 16, element width (Q4.12 vector)
ADDR_W, 14, weight SRAM word-address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  job request, held until gnt
job_rows  in  NUM_REQ*($clog2(MAX_ROWS)+1)  packed per-requester row count
job_cols  in  NUM_REQ*($clog2(MAX_COLS)+1)  packed per-requester col count
job_base  in  NUM_REQ*ADDR_W  packed per-requester matrix base address
gnt  out  NUM_REQ  one-hot grant, 1-cycle pulse
done  out  NUM_REQ  one-hot job-complete pulse
err  out  NUM_REQ  one-hot descriptor-rejected pulse
vec_valid  in  1  vector chunk valid (granted requester, muxed externally by owner)
vec_data  in  DATA_WIDTH*BANDWIDTH  vector chunk
vec_ready  out  1  chunk accepted when vec_valid&&vec_ready
eng_start  out  1  engine start pulse
eng_num_rows  out  $clog2(MAX_ROWS)+1  latched rows
eng_num_cols  out  $clog2(MAX_COLS)+1  latched cols
eng_vec_we  out  1  engine vector_write_enable
eng_vec_addr  out  $clog2(MAX_COLS)  engine vector_base_addr
eng_vec_data  out  DATA_WIDTH*BANDWIDTH  engine vector_in
eng_matrix_addr  in  $clog2(MAX_ROWS*MAX_COLS)  engine matrix address
eng_matrix_enable  in  1  engine matrix enable
eng_result  in  2*DATA_WIDTH  engine result (Q20.12)
eng_result_valid  in  1  engine result strobe
eng_busy  in  1  engine busy
mem_addr  out  ADDR_W  job_base + eng_matrix_addr (combinational, truncated to ADDR_W)
mem_enable  out  1  eng_matrix_enable pass-through
res_valid  out  1  registered result strobe
res_data  out  2*DATA_WIDTH  registered result
res_tag  out  $clog2(NUM_REQ)  owner of res_data
res_row  out  $clog2(MAX_ROWS)  row index of res_data
busy  out  1  state != S_IDLE

Behaviour:
- Reset: state S_IDLE, rr pointer 0, all counters 0; gnt, done, err, vec_ready, eng_start, eng_vec_we, res_valid = 0; eng_num_*, res_* = 0.
- S_IDLE: if any req, pick first set bit at or after rr pointer (wrapping); latch rows/cols/base/owner; go S_GRANT. No req -> stay.
- S_GRANT: gnt[owner]=1 for this cycle; rr pointer <= owner+1 mod NUM_REQ. Descriptor check: rows==0, cols==0, rows>MAX_ROWS or cols>MAX_COLS -> err[owner] pulse next cycle, return S_IDLE, engine untouched. Else -> S_START.
- S_START: eng_start=1 one cycle; -> S_VLOAD. Chunk counter and vector address cleared.
- S_VLOAD: vec_ready=1. On handshake: eng_vec_we=1 same cycle, eng_vec_data=vec_data, eng_vec_addr=chunk*BANDWIDTH. Chunks needed = ceil(cols/BANDWIDTH); after last accepted chunk -> S_RUN. vec_valid low -> eng_vec_we low, wait indefinitely.
- S_RUN: each eng_result_valid -> next cycle res_valid=1, res_data=eng_result, res_tag=owner, res_row=row counter; row counter++. After rows-th result -> S_DRAIN.
- S_DRAIN: wait eng_busy==0; then done[owner] pulse one cycle, -> S_IDLE. First new grant earliest the cycle after done.
- eng_result_valid outside S_RUN ignored (no res_valid).
- req dropped after grant has no effect on the running job; req is only sampled in S_IDLE.
- Reset mid-job: scheduler returns to S_IDLE next cycle; engine is reset by the same rst_n.
- mem_addr is valid in all states (combinational add); callers use only when mem_enable=1.

Decomposition:
- Package matvec_sched_pkg: state_t enum (S_IDLE, S_GRANT, S_START, S_VLOAD, S_RUN, S_DRAIN, one-hot), width localparams for rows/cols/tag.
- Sub-module rr_arbiter (NUM_REQ, req, ptr -> one-hot winner, winner index, any) instantiated once.

Test Plan:
- Single job req=0001, rows=4, cols=16, base=0x100: one chunk, eng_start once, 4 results with res_tag=0, res_row 0..3; done=0001 after eng_busy falls. eng_matrix_addr=5 -> mem_addr=0x105.
- cols=40, BANDWIDTH=16: exactly 3 chunks at eng_vec_addr 0,16,32. vec_valid stalled 5 cycles between chunks -> no eng_vec_we during the stall, no lost chunk.
- req=1111 held continuously: grants in order 0,1,2,3,0, with no requester granted twice before all four are served.
- Descriptor rows=0 on requester 2: err=0100 pulse, no eng_start, next pending requester granted afterwards.
- Stray eng_result_valid pulsed in S_VLOAD -> no res_valid, row counter unchanged.
- rst_n low during S_RUN: all outputs at reset values next cycle; a fresh job then completes normally.
